// File: rtl/alu_ctrl.sv
// alu_ctrl: valid/ready sequencer in front of the 32-bit ALU, with an iterative
// unsigned divide/modulo unit compiled in only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl #(
  parameter int unsigned STEPS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_int,
  output logic        busy,
  output logic        alu_en,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_data
);

  localparam int unsigned DW = 32;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ALU  = 2'd1,
    S_DIV  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          accept;
  logic          req_is_div;
  logic          req_ready_d;
  logic          busy_d;
  logic          rsp_valid_d;
  logic          alu_en_d;
  logic [DW-1:0] rsp_data_d;
  logic          rsp_int_d;

  assign accept     = req_valid && req_ready;
  assign req_is_div = (req_opcode[3:0] == OP_DIV) || (req_opcode[3:0] == OP_MOD);

`ifdef ALU_CTRL_DIV_EN
  localparam int unsigned N  = DW / STEPS;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] rem_d;
  logic [DW-1:0] quo_d;
  logic [DW:0]   trial;
  logic [CW-1:0] cnt_q;
  logic          div_zero;
  logic          div_last;
  logic          op_is_mod;

  assign div_zero  = (alu_b == '0);
  assign div_last  = (cnt_q == CW'(N - 1));
  assign op_is_mod = (alu_opcode[3:0] == OP_MOD);

  // STEPS restoring-division steps per clock, quotient bits enter at the LSB
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    trial = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      trial = {rem_d, quo_d[DW-1]};
      quo_d = {quo_d[DW-2:0], 1'b0};
      if (trial >= {1'b0, alu_b}) begin
        trial    = trial - {1'b0, alu_b};
        quo_d[0] = 1'b1;
      end
      rem_d = trial[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= req_a;
      cnt_q <= '0;
    end else if (state_q == S_DIV && !div_zero) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic op_is_div;
  logic unused_steps;

  assign op_is_div    = (alu_opcode[3:0] == OP_DIV) || (alu_opcode[3:0] == OP_MOD);
  assign unused_steps = (STEPS == 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_CTRL_DIV_EN
          state_d = req_is_div ? S_DIV : S_ALU;
`else
          state_d = S_ALU;
`endif
        end
      end
      S_ALU: state_d = S_RESP;
`ifdef ALU_CTRL_DIV_EN
      S_DIV: begin
        if (div_zero || div_last) begin
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; the result only changes on the edge entering RESP
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    alu_en_d    = (state_d == S_ALU) && !req_is_div;
    rsp_data_d  = rsp_data;
    rsp_int_d   = rsp_int;
    case (state_q)
      S_ALU: begin
`ifdef ALU_CTRL_DIV_EN
        rsp_data_d = alu_data;
        rsp_int_d  = 1'b0;
`else
        rsp_data_d = op_is_div ? '0 : alu_data;
        rsp_int_d  = op_is_div;
`endif
      end
`ifdef ALU_CTRL_DIV_EN
      S_DIV: begin
        if (div_zero) begin
          rsp_data_d = op_is_mod ? alu_a : '1;
          rsp_int_d  = 1'b1;
        end else if (div_last) begin
          rsp_data_d = op_is_mod ? rem_d : quo_d;
          rsp_int_d  = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_int   <= 1'b0;
      alu_en    <= 1'b0;
    end else begin
      req_ready <= req_ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_int   <= rsp_int_d;
      alu_en    <= alu_en_d;
    end
  end

  // Request latch, driven straight to the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (accept) begin
      alu_opcode <= req_opcode;
      alu_a      <= req_a;
      alu_b      <= req_b;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl; exercises the divider only when
// ALU_CTRL_DIV_EN is defined.
module tb_alu_ctrl;

  parameter int unsigned STEPS = 1;
  localparam int N = 32 / STEPS;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_int;
  logic        busy;
  logic        alu_en;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_data;
  logic [31:0] alu_model;

  int total = 0;
  int bad   = 0;

  alu_ctrl #(.STEPS(STEPS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_int(rsp_int),
    .busy(busy), .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy ALU: garbage whenever not enabled so stray sampling shows up
  always_comb begin
    case (alu_opcode[3:0])
      4'd0:    alu_model = alu_a + alu_b;
      4'd1:    alu_model = alu_a - alu_b;
      default: alu_model = alu_a ^ alu_b ^ {26'b0, alu_opcode};
    endcase
    alu_data = alu_en ? alu_model : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp_d,
                       input logic exp_i, input int exp_en);
    int   en_cnt;
    logic early;
    en_cnt = 0;
    early  = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_aop"}, 32'(alu_opcode), 32'(op));
    chk({tag, "_aa"}, alu_a, a);
    chk({tag, "_ab"}, alu_b, b);
    en_cnt += int'(alu_en);
    early  |= rsp_valid;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      en_cnt += int'(alu_en);
      early  |= rsp_valid;
    end
    @(posedge clk); #1;
    en_cnt += int'(alu_en);
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_en"}, 32'(en_cnt), 32'(exp_en));
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_dat"}, rsp_data, exp_d);
    chk({tag, "_int"}, 32'(rsp_int), 32'(exp_i));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_nrdy"}, 32'(req_ready), 32'd0);
  endtask

  // Handshake with rsp_ready already high, then back to IDLE
  task automatic rsp_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_vld0"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy1"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_dat"}, rsp_data, 32'd0);
    chk({tag, "_int"}, 32'(rsp_int), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"}, 32'(alu_en), 32'd0);
    chk({tag, "_aop"}, 32'(alu_opcode), 32'd0);
    chk({tag, "_aa"}, alu_a, 32'd0);
    chk({tag, "_ab"}, alu_b, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    #2;
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_rdy_up", 32'(req_ready), 32'd1);

    do_op("add", 6'h00, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1);
    rsp_done("add");
    do_op("flag", 6'h3d, 32'h0F0F_0000, 32'h0000_00FF, 1, 32'h0F0F_00C2, 1'b0, 1);
    rsp_done("flag");
    do_op("mulh", 6'h02, 32'd3, 32'd5, 1, 32'd4, 1'b0, 1);
    rsp_done("mulh");

`ifdef ALU_CTRL_DIV_EN
    do_op("div", 6'h04, 32'd100, 32'd7, N, 32'd14, 1'b0, 0);
    rsp_done("div");
    do_op("mod", 6'h05, 32'd100, 32'd7, N, 32'd2, 1'b0, 0);
    rsp_done("mod");
    do_op("divmax", 6'h04, 32'hFFFF_FFFF, 32'd1, N, 32'hFFFF_FFFF, 1'b0, 0);
    rsp_done("divmax");
    do_op("div3", 6'h04, 32'h8000_0000, 32'd3, N, 32'h2AAA_AAAA, 1'b0, 0);
    rsp_done("div3");
    do_op("mod3", 6'h05, 32'h8000_0000, 32'd3, N, 32'd2, 1'b0, 0);
    rsp_done("mod3");
    do_op("div0", 6'h04, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b1, 0);
    rsp_done("div0");
    do_op("mod0", 6'h05, 32'd9, 32'd0, 1, 32'd9, 1'b1, 0);
    rsp_done("mod0");
    do_op("div0hi", 6'h24, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b1, 0);
    rsp_done("div0hi");
`else
    do_op("ill5", 6'h05, 32'd17, 32'd5, 1, 32'd0, 1'b1, 0);
    rsp_done("ill5");
    do_op("ill4", 6'h04, 32'd9, 32'd0, 1, 32'd0, 1'b1, 0);
    rsp_done("ill4");
    do_op("ill24", 6'h24, 32'd9, 32'd3, 1, 32'd0, 1'b1, 0);
    rsp_done("ill24");
`endif

    // Backpressure with a second request held during busy
    rsp_ready = 1'b0;
    do_op("sub", 6'h01, 32'd10, 32'd3, 1, 32'd7, 1'b0, 1);
    req_valid  = 1'b1;
    req_opcode = 6'h00;
    req_a      = 32'd1;
    req_b      = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_dat", rsp_data, 32'd7);
      chk("bp_rdy", 32'(req_ready), 32'd0);
      chk("bp_en", 32'(alu_en), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_vld", 32'(rsp_valid), 32'd0);
    chk("bp_hs_rdy", 32'(req_ready), 32'd1);
    chk("bp_hs_en", 32'(alu_en), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_acc_en", 32'(alu_en), 32'd1);
    chk("bp_acc_aa", alu_a, 32'd1);
    @(posedge clk); #1;
    chk("bp2_vld", 32'(rsp_valid), 32'd1);
    chk("bp2_dat", rsp_data, 32'd2);
    rsp_done("bp2");

    // Reset in the middle of an operation
`ifdef ALU_CTRL_DIV_EN
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = 6'h04;
    req_a      = 32'd100;
    req_b      = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat ((N > 10) ? 9 : N / 2) @(posedge clk);
    #1;
`else
    rsp_ready = 1'b0;
    do_op("pre", 6'h00, 32'd1, 32'd2, 1, 32'd3, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;
`endif
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rdy_up", 32'(req_ready), 32'd1);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
`ifdef ALU_CTRL_DIV_EN
    do_op("post", 6'h05, 32'd17, 32'd5, N, 32'd2, 1'b0, 0);
`else
    do_op("post", 6'h05, 32'd17, 32'd5, 1, 32'd0, 1'b1, 0);
`endif
    rsp_done("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
